// File: rtl/dnn_mlp_seq_if.sv
// -----------------------------------------------------------------------------
// dnn_mlp_seq_if
// Handshake/data bundle for the sequential two-layer MLP block.
//   in_valid / in_ready   : operand-set handshake (loader -> block)
//   x_flat                : N_IN activations, x[i] at [i*DW +: DW]
//   w1_flat               : layer-1 weights, w1[i][j] at [(j*N_IN+i)*DW +: DW]
//   w2_flat               : layer-2 weights, w2[j][k] at [(k*N_HID+j)*DW +: DW]
//   out_valid / out_ready : result handshake (block -> collector)
//   out_flat              : N_OUT results, out[k] at [k*OW +: OW]
// Modports: master = producer/consumer side, slave = the MLP block.
// -----------------------------------------------------------------------------
interface dnn_mlp_seq_if #(
   parameter int N_IN  = 4,
   parameter int N_HID = 4,
   parameter int N_OUT = 2,
   parameter int DW    = 5,
   parameter int OW    = 17
);
   logic                      in_valid;
   logic                      in_ready;
   logic [N_IN*DW-1:0]        x_flat;
   logic [N_IN*N_HID*DW-1:0]  w1_flat;
   logic [N_HID*N_OUT*DW-1:0] w2_flat;
   logic                      out_valid;
   logic                      out_ready;
   logic [N_OUT*OW-1:0]       out_flat;

   modport master (
      output in_valid, x_flat, w1_flat, w2_flat, out_ready,
      input  in_ready, out_valid, out_flat
   );

   modport slave (
      input  in_valid, x_flat, w1_flat, w2_flat, out_ready,
      output in_ready, out_valid, out_flat
   );
endinterface

// File: rtl/dnn_mlp_seq.sv
// -----------------------------------------------------------------------------
// dnn_mlp_seq
// Two-layer fully-connected inference (N_IN -> N_HID -> N_OUT) computed with a
// single time-multiplexed multiply-accumulate unit under a small FSM.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : dnn_mlp_seq_if.slave (operand and result handshakes, flat buses)
// Hidden activations are saturated to HW bits, outputs to OW bits.
// Optional macro DNN_MLP_RELU_EN: apply ReLU to each hidden activation before
// it is stored (output layer stays linear).
// -----------------------------------------------------------------------------
module dnn_mlp_seq #(
   parameter int N_IN  = 4,
   parameter int N_HID = 4,
   parameter int N_OUT = 2,
   parameter int DW    = 5,
   parameter int HW    = 12,
   parameter int OW    = 17
) (
   input logic          clk,
   input logic          rst_n,
   dnn_mlp_seq_if.slave bus
);
   localparam int IW  = (N_IN  > 1) ? $clog2(N_IN)  : 1;
   localparam int JW  = (N_HID > 1) ? $clog2(N_HID) : 1;
   localparam int KW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int AW1 = 2*DW + $clog2(N_IN);
   localparam int AW2 = HW + DW + $clog2(N_HID);
   localparam int AW  = (AW1 > AW2) ? AW1 : AW2;

   localparam longint H_MAX = (longint'(1) << (HW-1)) - 1;
   localparam longint H_MIN = -H_MAX - 1;
   localparam longint O_MAX = (longint'(1) << (OW-1)) - 1;
   localparam longint O_MIN = -O_MAX - 1;

   function automatic logic signed [HW-1:0] sat_hw(input logic signed [AW-1:0] v);
      if (longint'(v) > H_MAX) return HW'(H_MAX);
      if (longint'(v) < H_MIN) return HW'(H_MIN);
      return v[HW-1:0];
   endfunction

   function automatic logic signed [OW-1:0] sat_ow(input logic signed [AW-1:0] v);
      if (longint'(v) > O_MAX) return OW'(O_MAX);
      if (longint'(v) < O_MIN) return OW'(O_MIN);
      return OW'(v);
   endfunction

   function automatic logic signed [HW-1:0] hid_act(input logic signed [HW-1:0] v);
`ifdef DNN_MLP_RELU_EN
      return (v < 0) ? '0 : v;
`else
      return v;
`endif
   endfunction

   typedef enum logic [2:0] {S_IDLE, S_L1, S_L2, S_FIN, S_DONE} state_t;
   state_t state_q, state_d;

   logic [N_IN*DW-1:0]        x_q,  x_d;
   logic [N_IN*N_HID*DW-1:0]  w1_q, w1_d;
   logic [N_HID*N_OUT*DW-1:0] w2_q, w2_d;
   logic signed [AW-1:0]      acc_q, acc_d;
   logic [IW-1:0]             i_q, i_d;
   logic [JW-1:0]             j_q, j_d;
   logic [KW-1:0]             k_q, k_d;
   logic signed [HW-1:0]      hid_q [N_HID];
   logic signed [HW-1:0]      hid_d [N_HID];
   logic signed [OW-1:0]      res_q [N_OUT];
   logic signed [OW-1:0]      res_d [N_OUT];
   logic [N_OUT*OW-1:0]       out_q, out_d;

   // Signed views of the captured operand buses
   logic signed [DW-1:0] x_a  [N_IN];
   logic signed [DW-1:0] w1_a [N_HID][N_IN];
   logic signed [DW-1:0] w2_a [N_OUT][N_HID];

   for (genvar gi = 0; gi < N_IN; gi++) begin : g_x
      assign x_a[gi] = x_q[gi*DW +: DW];
      for (genvar gj = 0; gj < N_HID; gj++) begin : g_w1
         assign w1_a[gj][gi] = w1_q[(gj*N_IN+gi)*DW +: DW];
      end
   end
   for (genvar gj = 0; gj < N_HID; gj++) begin : g_h
      for (genvar gk = 0; gk < N_OUT; gk++) begin : g_w2
         assign w2_a[gk][gj] = w2_q[(gk*N_HID+gj)*DW +: DW];
      end
   end

   // Shared MAC: operand pair selected by the current layer
   logic signed [2*DW-1:0]  p1;
   logic signed [HW+DW-1:0] p2;
   logic signed [AW-1:0]    sum;

   assign p1  = (2*DW)'(x_a[i_q]) * (2*DW)'(w1_a[j_q][i_q]);
   assign p2  = (HW+DW)'(hid_q[j_q]) * (HW+DW)'(w2_a[k_q][j_q]);
   assign sum = acc_q + ((state_q == S_L2) ? AW'(p2) : AW'(p1));

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      w1_d    = w1_q;
      w2_d    = w2_q;
      acc_d   = acc_q;
      i_d     = i_q;
      j_d     = j_q;
      k_d     = k_q;
      hid_d   = hid_q;
      res_d   = res_q;
      out_d   = out_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               x_d     = bus.x_flat;
               w1_d    = bus.w1_flat;
               w2_d    = bus.w2_flat;
               acc_d   = '0;
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
               state_d = S_L1;
            end
         end
         S_L1: begin
            if (i_q == IW'(N_IN-1)) begin
               hid_d[j_q] = hid_act(sat_hw(sum));
               acc_d      = '0;
               i_d        = '0;
               if (j_q == JW'(N_HID-1)) begin
                  j_d     = '0;
                  state_d = S_L2;
               end else begin
                  j_d = j_q + JW'(1);
               end
            end else begin
               acc_d = sum;
               i_d   = i_q + IW'(1);
            end
         end
         S_L2: begin
            if (j_q == JW'(N_HID-1)) begin
               res_d[k_q] = sat_ow(sum);
               acc_d      = '0;
               j_d        = '0;
               if (k_q == KW'(N_OUT-1)) begin
                  k_d     = '0;
                  state_d = S_FIN;
               end else begin
                  k_d = k_q + KW'(1);
               end
            end else begin
               acc_d = sum;
               j_d   = j_q + JW'(1);
            end
         end
         // Staged results are published together so out_flat never shows a
         // partially updated result set.
         S_FIN: begin
            for (int k = 0; k < N_OUT; k++) out_d[k*OW +: OW] = res_q[k];
            state_d = S_DONE;
         end
         S_DONE: begin
            if (bus.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         w1_q    <= '0;
         w2_q    <= '0;
         acc_q   <= '0;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         for (int n = 0; n < N_HID; n++) hid_q[n] <= '0;
         for (int n = 0; n < N_OUT; n++) res_q[n] <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         w1_q    <= w1_d;
         w2_q    <= w2_d;
         acc_q   <= acc_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         hid_q   <= hid_d;
         res_q   <= res_d;
         out_q   <= out_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.out_flat  = out_q;
endmodule

// File: tb/tb_dnn_mlp_seq.sv
// -----------------------------------------------------------------------------
// tb_dnn_mlp_seq
// Drives two instances in lockstep: default parameters (HW=12) and HW=10.
// Expected results come from hand-derived constants and a behavioural model.
// -----------------------------------------------------------------------------
module tb_dnn_mlp_seq;
   localparam int N_IN  = 4;
   localparam int N_HID = 4;
   localparam int N_OUT = 2;
   localparam int DW    = 5;
   localparam int OW    = 17;
   localparam int XW    = N_IN*DW;
   localparam int W1W   = N_IN*N_HID*DW;
   localparam int W2W   = N_HID*N_OUT*DW;
   localparam int RW    = N_OUT*OW;
   localparam int NV    = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   dnn_mlp_seq_if #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .DW(DW), .OW(OW)) ba ();
   dnn_mlp_seq_if #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .DW(DW), .OW(OW)) bb ();

   dnn_mlp_seq #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .DW(DW), .HW(12), .OW(OW))
      u_dut12 (.clk(clk), .rst_n(rst_n), .bus(ba));
   dnn_mlp_seq #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .DW(DW), .HW(10), .OW(OW))
      u_dut10 (.clk(clk), .rst_n(rst_n), .bus(bb));

   typedef struct {
      logic [XW-1:0]  x;
      logic [W1W-1:0] w1;
      logic [W2W-1:0] w2;
      logic [RW-1:0]  e12;
      logic [RW-1:0]  e10;
   } vec_t;

   vec_t          tbl [NV];
   logic [RW-1:0] sb_a [$];
   logic [RW-1:0] sb_b [$];
   int            n_chk  = 0;
   int            n_pass = 0;

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0b expected %0b", nm, act, exp);
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic chkw(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic logic [RW-1:0] pk(input longint a, input longint b);
      logic [RW-1:0] r;
      r[OW-1:0]    = a[OW-1:0];
      r[RW-1:OW]   = b[OW-1:0];
      return r;
   endfunction

   function automatic longint sat(input longint v, input int w);
      longint lim;
      lim = longint'(1) << (w-1);
      if (v > lim-1) return lim-1;
      if (v < -lim) return -lim;
      return v;
   endfunction

   function automatic logic [RW-1:0] model(input logic [XW-1:0] x, input logic [W1W-1:0] w1,
                                           input logic [W2W-1:0] w2, input int hw);
      longint h [N_HID];
      longint s;
      longint o;
      logic signed [DW-1:0] a;
      logic signed [DW-1:0] b;
      logic [RW-1:0] r;
      r = '0;
      for (int j = 0; j < N_HID; j++) begin
         s = 0;
         for (int i = 0; i < N_IN; i++) begin
            a = x[i*DW +: DW];
            b = w1[(j*N_IN+i)*DW +: DW];
            s += longint'(a) * longint'(b);
         end
         h[j] = sat(s, hw);
`ifdef DNN_MLP_RELU_EN
         if (h[j] < 0) h[j] = 0;
`endif
      end
      for (int k = 0; k < N_OUT; k++) begin
         s = 0;
         for (int j = 0; j < N_HID; j++) begin
            b = w2[(k*N_HID+j)*DW +: DW];
            s += h[j] * longint'(b);
         end
         o = sat(s, OW);
         r[k*OW +: OW] = o[OW-1:0];
      end
      return r;
   endfunction

   task automatic drive(input logic [XW-1:0] x, input logic [W1W-1:0] w1,
                        input logic [W2W-1:0] w2, input logic v);
      ba.x_flat = x;  ba.w1_flat = w1;  ba.w2_flat = w2;  ba.in_valid = v;
      bb.x_flat = x;  bb.w1_flat = w1;  bb.w2_flat = w2;  bb.in_valid = v;
   endtask

   task automatic set_ready(input logic r);
      ba.out_ready = r;
      bb.out_ready = r;
   endtask

   // Wait (bounded) for out_valid after the accepting edge; returns edge count.
   task automatic wait_out(output int lat);
      lat = 0;
      while (!ba.out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      set_ready(1'b1);
      @(negedge clk);
      chk1("in_ready_idle", ba.in_ready & bb.in_ready, 1'b1);
      drive(v.x, v.w1, v.w2, 1'b1);
      @(posedge clk);
      sb_a.push_back(v.e12);
      sb_b.push_back(v.e10);
      #1;
      drive(~v.x, ~v.w1, ~v.w2, 1'b0);
      chk1("in_ready_busy", ba.in_ready, 1'b0);
      wait_out(lat);
      chki("latency", lat, 25);
      chk1("out_valid_hw10", bb.out_valid, 1'b1);
      chkw("out_hw12", ba.out_flat, sb_a.pop_front());
      chkw("out_hw10", bb.out_flat, sb_b.pop_front());
      @(posedge clk); #1;
      chk1("out_valid_drop", ba.out_valid | bb.out_valid, 1'b0);
      chk1("in_ready_after", ba.in_ready & bb.in_ready, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [RW-1:0] hold_a;
      int lat;
      vec_t t;

      rst_n = 1'b1;
      set_ready(1'b1);
      drive('0, '0, '0, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      chk1("rst_in_ready", ba.in_ready & bb.in_ready, 1'b1);
      chk1("rst_out_valid", ba.out_valid | bb.out_valid, 1'b0);
      chkw("rst_out_flat", ba.out_flat | bb.out_flat, '0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // all +15: hidden 900 (or 511 when HW=10)
      tbl[0] = '{x: {N_IN{5'd15}}, w1: {(N_IN*N_HID){5'd15}}, w2: {(N_HID*N_OUT){5'd15}},
                 e12: pk(54000, 54000), e10: pk(30660, 30660)};
      // one hidden neuron negative (-225), others +225
`ifdef DNN_MLP_RELU_EN
      tbl[1] = '{x: {5'd0, 5'd0, 5'd0, 5'd15}, w1: {{15{5'd15}}, 5'b10001},
                 w2: {(N_HID*N_OUT){5'd1}}, e12: pk(675, 675), e10: pk(675, 675)};
`else
      tbl[1] = '{x: {5'd0, 5'd0, 5'd0, 5'd15}, w1: {{15{5'd15}}, 5'b10001},
                 w2: {(N_HID*N_OUT){5'd1}}, e12: pk(450, 450), e10: pk(450, 450)};
`endif
      tbl[2] = '{x: '0, w1: '0, w2: '0, e12: pk(0, 0), e10: pk(0, 0)};
      // all -16: hidden +1024 (511 at HW=10), outputs hit -65536 / -32704
      tbl[3] = '{x: {N_IN{5'b10000}}, w1: {(N_IN*N_HID){5'b10000}}, w2: {(N_HID*N_OUT){5'b10000}},
                 e12: pk(-65536, -65536), e10: pk(-32704, -32704)};
      // hidden -960 (-512 at HW=10), w2=-16
`ifdef DNN_MLP_RELU_EN
      tbl[4] = '{x: {N_IN{5'b10000}}, w1: {(N_IN*N_HID){5'd15}}, w2: {(N_HID*N_OUT){5'b10000}},
                 e12: pk(0, 0), e10: pk(0, 0)};
`else
      tbl[4] = '{x: {N_IN{5'b10000}}, w1: {(N_IN*N_HID){5'd15}}, w2: {(N_HID*N_OUT){5'b10000}},
                 e12: pk(61440, 61440), e10: pk(32768, 32768)};
`endif
      for (int v = 5; v < NV; v++) begin
         tbl[v].x   = XW'($urandom);
         tbl[v].w1  = W1W'({$urandom, $urandom, $urandom});
         tbl[v].w2  = W2W'({$urandom, $urandom});
         tbl[v].e12 = model(tbl[v].x, tbl[v].w1, tbl[v].w2, 12);
         tbl[v].e10 = model(tbl[v].x, tbl[v].w1, tbl[v].w2, 10);
      end

      for (int v = 0; v < NV; v++) run_vec(tbl[v]);

      // Backpressure: result held while out_ready is low, inputs wiggle
      t = tbl[0];
      set_ready(1'b0);
      @(negedge clk);
      drive(t.x, t.w1, t.w2, 1'b1);
      @(posedge clk);
      sb_a.push_back(t.e12);
      #1;
      drive(t.x, t.w1, t.w2, 1'b0);
      wait_out(lat);
      chki("bp_latency", lat, 25);
      hold_a = sb_a.pop_front();
      chkw("bp_out", ba.out_flat, hold_a);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         drive(XW'($urandom), t.w1, t.w2, (c >= 5));
         @(posedge clk); #1;
         chkw("bp_out_stable", ba.out_flat, hold_a);
         chk1("bp_out_valid", ba.out_valid, 1'b1);
         chk1("bp_in_ready", ba.in_ready, 1'b0);
      end
      @(negedge clk);
      drive(t.x, t.w1, t.w2, 1'b0);
      set_ready(1'b1);
      @(posedge clk); #1;
      chk1("bp_xfer_valid", ba.out_valid, 1'b0);
      chk1("bp_xfer_ready", ba.in_ready, 1'b1);
      @(negedge clk) set_ready(1'b0);
      repeat (3) begin
         @(posedge clk); #1;
         chk1("bp_no_requeue", ba.in_ready & ~ba.out_valid, 1'b1);
      end

      // Reset abort partway through layer 1
      set_ready(1'b1);
      @(negedge clk);
      drive(t.x, t.w1, t.w2, 1'b1);
      @(posedge clk); #1;
      drive(t.x, t.w1, t.w2, 1'b0);
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk1("abort_out_valid", ba.out_valid | bb.out_valid, 1'b0);
      chkw("abort_out_flat_hw12", ba.out_flat, '0);
      chkw("abort_out_flat_hw10", bb.out_flat, '0);
      chk1("abort_in_ready", ba.in_ready & bb.in_ready, 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      #1;
      chk1("abort_in_ready_rel", ba.in_ready, 1'b1);
      run_vec(tbl[0]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
